frame_buf_scheduler: RTL and testbench
======================================

// Module: frame_buf_scheduler
// PURPOSE
//  Triple-buffer bank scheduler for the camera frame store. It hands the camera writer and the
//  VGA reader disjoint bank indices and base addresses, and swaps banks only at frame boundaries,
//  so display never tears. Runs in the pixel-clock domain; frame-event pulses arrive synchronised.
//  Downstream address = base + in-frame offset.
// PARAMETERS
//  BANK_DEPTH  32768  words per bank; base = bank_idx*BANK_DEPTH
//  ADDR_W      17     width of wr_base/rd_base
//  TIMEOUT     2000000 max clk cycles from wr_frame_start to wr_frame_end before the frame is aborted
//  CNT_W       8      width of saturating status counters
// PORTS
//  clk            in   1       scheduler clock
//  rst            in   1       synchronous reset, active-high
//  wr_frame_start in   1       1-cycle pulse: camera frame begins (vsync edge, pre-synchronised)
//  wr_frame_end   in   1       1-cycle pulse: last pixel of camera frame written
//  rd_frame_start in   1       1-cycle pulse: VGA vertical blank start
//  wr_en          out  1       writer may store pixels (high only in WRITE)
//  wr_bank        out  2       bank index being written
//  wr_base        out  ADDR_W  wr_bank*BANK_DEPTH
//  rd_bank        out  2       bank index being displayed
//  rd_base        out  ADDR_W  rd_bank*BANK_DEPTH
//  rd_valid       out  1       at least one complete frame shown; reader blanks when low
//  drop_cnt       out  CNT_W   completed frames overwritten before display (saturating)
//  abort_cnt      out  CNT_W   frames discarded by restart or timeout (saturating)
// BEHAVIOUR
//  - State regs: w_idx, r_idx, p_idx (pending), p_fresh, wr_state {IDLE, WRITE}, timeout ctr.
//  - Invariant: {w_idx, r_idx, p_idx} is always a permutation of {0,1,2}.
//  - Reset: w=0, p=1, r=2, p_fresh=0, IDLE, wr_en=0, rd_valid=0, counters=0, bases match idx.
//  - All outputs are registered and update the cycle after the causing pulse.
//  - IDLE: wr_frame_start -> WRITE, timeout ctr=0. wr_frame_end is ignored.
//  - WRITE, wr_frame_end:
//    - swap w<->p; p_fresh=1.
//    - If p_fresh was already 1, drop_cnt++.
//    - Go to IDLE.
//  - WRITE, wr_frame_start (no end): restart on the same bank; abort_cnt++; timeout ctr=0.
//  - WRITE, end and start in the same cycle: do the end first (swap), then stay in WRITE
//    on the new w bank with timeout ctr=0.
//  - WRITE, timeout ctr reaches TIMEOUT-1 with no end:
//    - go to IDLE; abort_cnt++; banks unchanged; partial frame discarded.
//  - rd_frame_start with p_fresh=1: swap r<->p; p_fresh=0; rd_valid=1 (sticky until rst).
//  - rd_frame_start with p_fresh=0: r unchanged; the same frame repeats.
//  - wr_frame_end and rd_frame_start in the same cycle: apply the write swap first, then the
//    read swap. Net result: r=old w, w=old p, p=old r, p_fresh=0.
//    drop_cnt++ if old p_fresh was 1.
//  - rd_bank changes only on rd_frame_start; wr_bank changes only on wr_frame_end.
//  - Counters hold at 2^CNT_W-1. rst mid-frame returns everything to reset values next cycle.
// STRUCTURE
//  - Shared package fb_pkg:
//    - bank_idx_t (2b); wr_state_t enum {IDLE, WRITE}; NUM_BANKS=3.
//    - Reset bank constants W0=0, P0=1, R0=2.
//  - Sub-module sat_counter #(CNT_W), instantiated for drop_cnt and abort_cnt.
//  - Bank rotation and the writer FSM stay in this module.
// TESTING
//  1. rst; start; end; rd_start.
//     -> after end: wr_bank=1. After rd_start: rd_bank=0, rd_valid=1, wr_bank=1.
//  2. From rst: two start/end pairs, no read; then rd_start.
//     -> drop_cnt=1, rd_bank=1, wr_bank=0.
//  3. After test 1, rd_start with no new frame.
//     -> rd_bank stays 0, drop_cnt unchanged.
//  4. After test 1 (w1,p2,r0): start, then end and rd_start in the same cycle.
//     -> wr_bank=2, rd_bank=1, p=0, drop_cnt=0.
//  5. TIMEOUT=100: start, no end for 100 cycles.
//     -> wr_en falls, abort_cnt=1, wr_bank=0, rd_valid=0.
//  6. rst asserted mid-WRITE after a completed frame.
//     -> next cycle wr_bank=0, rd_bank=2, rd_valid=0, wr_en=0, counters=0.
//  Every test checks the permutation invariant each cycle.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the triple-buffer frame store scheduler.
package fb_pkg;

  typedef logic [1:0] bank_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

  localparam int unsigned NUM_BANKS = 3;

  // Bank roles coming out of reset: writer, pending, reader.
  localparam bank_idx_t W0 = 2'd0;
  localparam bank_idx_t P0 = 2'd1;
  localparam bank_idx_t R0 = 2'd2;

  // Word address of the first location of a bank.
  function automatic int unsigned bank_base(input bank_idx_t idx, input int unsigned depth);
    return int'(idx) * depth;
  endfunction

endpackage

// File: rtl/frame_buf_scheduler_sat_counter.sv
// Saturating up-counter used for the scheduler's status counters.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increment requests, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_buf_scheduler.sv
// Triple-buffer bank scheduler: keeps writer, pending and reader banks
// disjoint and rotates them only at frame boundaries.
module frame_buf_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned BANK_DEPTH = 32768,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned TIMEOUT    = 2000000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_frame_start,
  input  logic              wr_frame_end,
  input  logic              rd_frame_start,
  output logic              wr_en,
  output logic [1:0]        wr_bank,
  output logic [ADDR_W-1:0] wr_base,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] rd_base,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  bank_idx_t        w_idx, p_idx, r_idx;
  bank_idx_t        w_n, p_n, r_n;
  logic             p_fresh, fresh_n;
  wr_state_t        wr_state, state_n;
  logic [TMO_W-1:0] tmo_ctr, tmo_n;
  logic             valid_n;
  logic             drop_inc, abort_inc;

  // Next-state: the write-side swap is resolved first so a same-cycle
  // read swap picks up the frame that has just completed.
  always_comb begin
    w_n       = w_idx;
    p_n       = p_idx;
    r_n       = r_idx;
    fresh_n   = p_fresh;
    state_n   = wr_state;
    tmo_n     = tmo_ctr;
    valid_n   = rd_valid;
    drop_inc  = 1'b0;
    abort_inc = 1'b0;

    if (wr_state == WRITE) begin
      if (wr_frame_end) begin
        w_n      = p_idx;
        p_n      = w_idx;
        fresh_n  = 1'b1;
        drop_inc = p_fresh;
        state_n  = wr_frame_start ? WRITE : IDLE;
        tmo_n    = '0;
      end else if (wr_frame_start) begin
        abort_inc = 1'b1;
        tmo_n     = '0;
      end else if (tmo_ctr == TMO_LAST) begin
        abort_inc = 1'b1;
        state_n   = IDLE;
        tmo_n     = '0;
      end else begin
        tmo_n = tmo_ctr + TMO_W'(1);
      end
    end else if (wr_frame_start) begin
      state_n = WRITE;
      tmo_n   = '0;
    end

    if (rd_frame_start && fresh_n) begin
      r_n     = p_n;
      p_n     = r_idx;
      fresh_n = 1'b0;
      valid_n = 1'b1;
    end
  end

  // Register bank roles, writer FSM and all derived outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx    <= W0;
      p_idx    <= P0;
      r_idx    <= R0;
      p_fresh  <= 1'b0;
      wr_state <= IDLE;
      tmo_ctr  <= '0;
      wr_en    <= 1'b0;
      rd_valid <= 1'b0;
      wr_base  <= ADDR_W'(bank_base(W0, BANK_DEPTH));
      rd_base  <= ADDR_W'(bank_base(R0, BANK_DEPTH));
    end else begin
      w_idx    <= w_n;
      p_idx    <= p_n;
      r_idx    <= r_n;
      p_fresh  <= fresh_n;
      wr_state <= state_n;
      tmo_ctr  <= tmo_n;
      wr_en    <= (state_n == WRITE);
      rd_valid <= valid_n;
      wr_base  <= ADDR_W'(bank_base(w_n, BANK_DEPTH));
      rd_base  <= ADDR_W'(bank_base(r_n, BANK_DEPTH));
    end
  end

  assign wr_bank = w_idx;
  assign rd_bank = r_idx;

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_abort_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (abort_inc),
    .count (abort_cnt)
  );

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Self-checking bench for frame_buf_scheduler: directed vector table,
// hand-written corner sequences and random events against a frame-role model.
module tb_frame_buf_scheduler;

  localparam int unsigned BANK_DEPTH = 32768;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned TIMEOUT    = 100;
  localparam int unsigned CNT_W      = 8;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_frame_start = 1'b0;
  logic              wr_frame_end = 1'b0;
  logic              rd_frame_start = 1'b0;
  logic              wr_en;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_base;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_base;
  logic              rd_valid;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  abort_cnt;

  frame_buf_scheduler #(
    .BANK_DEPTH (BANK_DEPTH),
    .ADDR_W     (ADDR_W),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_frame_start (wr_frame_start),
    .wr_frame_end   (wr_frame_end),
    .rd_frame_start (rd_frame_start),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_base        (wr_base),
    .rd_bank        (rd_bank),
    .rd_base        (rd_base),
    .rd_valid       (rd_valid),
    .drop_cnt       (drop_cnt),
    .abort_cnt      (abort_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which bank holds the frame being written, the newest
  // finished frame, and the frame on screen; plus frame age and status.
  int m_write, m_pend, m_show;
  bit m_fresh, m_busy, m_valid;
  int m_age, m_drop, m_abort;

  function automatic void model_reset();
    m_write = 0; m_pend = 1; m_show = 2;
    m_fresh = 0; m_busy = 0; m_valid = 0;
    m_age = 0; m_drop = 0; m_abort = 0;
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit e, input bit rd);
    int t;
    if (r) begin
      model_reset();
      return;
    end
    if (m_busy && e) begin
      t = m_write; m_write = m_pend; m_pend = t;
      if (m_fresh) m_drop = (m_drop < CNT_MAX) ? m_drop + 1 : CNT_MAX;
      m_fresh = 1;
      m_busy = s;
      m_age = 0;
    end else if (m_busy && s) begin
      m_abort = (m_abort < CNT_MAX) ? m_abort + 1 : CNT_MAX;
      m_age = 0;
    end else if (m_busy) begin
      if (m_age + 1 >= TIMEOUT) begin
        m_busy = 0;
        m_abort = (m_abort < CNT_MAX) ? m_abort + 1 : CNT_MAX;
      end else begin
        m_age++;
      end
    end else if (s) begin
      m_busy = 1;
      m_age = 0;
    end
    if (rd && m_fresh) begin
      t = m_show; m_show = m_pend; m_pend = t;
      m_fresh = 0;
      m_valid = 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("wr_bank", 32'(wr_bank), m_write);
    check("rd_bank", 32'(rd_bank), m_show);
    check("wr_base", 32'(wr_base), m_write * BANK_DEPTH);
    check("rd_base", 32'(rd_base), m_show * BANK_DEPTH);
    check("wr_en", 32'(wr_en), 32'(m_busy));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("drop_cnt", 32'(drop_cnt), m_drop);
    check("abort_cnt", 32'(abort_cnt), m_abort);
    // Three roles must occupy three distinct banks.
    check("perm_wr_ne_rd", 32'(wr_bank != rd_bank), 1);
    check("perm_range", 32'((wr_bank < 2'd3) && (rd_bank < 2'd3)), 1);
  endtask

  task automatic step(input bit r, input bit s, input bit e, input bit rd);
    @(negedge clk);
    rst = r; wr_frame_start = s; wr_frame_end = e; rd_frame_start = rd;
    @(posedge clk);
    model_step(r, s, e, rd);
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, s, e, rd;
    int wb, rb;
    bit en, v;
    int d, a;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit e, input bit rd,
                              input int wb, input int rb, input bit en, input bit v,
                              input int d, input int a);
    vec_t x;
    x.rst = r; x.s = s; x.e = e; x.rd = rd;
    x.wb = wb; x.rb = rb; x.en = en; x.v = v; x.d = d; x.a = a;
    return x;
  endfunction

  vec_t tbl[23];

  initial begin
    // rst, start, end, rd  ->  wr_bank, rd_bank, wr_en, rd_valid, drop, abort
    tbl[0]  = mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 1, 2, 1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 1, 2, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 2, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 1, 1, 1, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 2, 1, 0, 1, 1, 0);
    tbl[15] = mk(0, 1, 0, 0, 2, 1, 1, 1, 1, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 2, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 1, 0, 1, 2, 0, 0, 0, 1);
    tbl[20] = mk(0, 1, 1, 0, 1, 2, 1, 0, 0, 1);
    tbl[21] = mk(0, 1, 1, 0, 0, 2, 1, 0, 1, 1);
    tbl[22] = mk(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);

    model_reset();

    // Directed vectors.
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].s, tbl[i].e, tbl[i].rd);
      check("vec_wr_bank", 32'(wr_bank), tbl[i].wb);
      check("vec_rd_bank", 32'(rd_bank), tbl[i].rb);
      check("vec_wr_base", 32'(wr_base), tbl[i].wb * BANK_DEPTH);
      check("vec_rd_base", 32'(rd_base), tbl[i].rb * BANK_DEPTH);
      check("vec_wr_en", 32'(wr_en), 32'(tbl[i].en));
      check("vec_rd_valid", 32'(rd_valid), 32'(tbl[i].v));
      check("vec_drop_cnt", 32'(drop_cnt), tbl[i].d);
      check("vec_abort_cnt", 32'(abort_cnt), tbl[i].a);
    end

    // Timeout: writer stays enabled for exactly TIMEOUT cycles after start.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int unsigned i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
    check("tmo_en_before", 32'(wr_en), 1);
    check("tmo_abort_before", 32'(abort_cnt), 0);
    step(0, 0, 0, 0);
    check("tmo_en_after", 32'(wr_en), 0);
    check("tmo_abort_after", 32'(abort_cnt), 1);
    check("tmo_wr_bank", 32'(wr_bank), 0);
    check("tmo_rd_valid", 32'(rd_valid), 0);

    // Drop counter saturation: many finished frames, never displayed.
    step(1, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
    end
    check("drop_sat", 32'(drop_cnt), CNT_MAX);

    // Abort counter saturation: repeated restarts.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 260; i++) step(0, 1, 0, 0);
    check("abort_sat", 32'(abort_cnt), CNT_MAX);
    check("abort_sat_en", 32'(wr_en), 1);

    // Random frame events, including long quiet stretches that time out.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, s, e, rd;
      r  = ($urandom_range(0, 399) == 0);
      s  = ($urandom_range(0, 99) < 3);
      e  = ($urandom_range(0, 99) < 2);
      rd = ($urandom_range(0, 99) < 4);
      step(r, s, e, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
